// File: rtl/tinyalu.sv
// ---------------------------------------------------------------------------
// tinyalu -- small unsigned ALU with a start/done handshake.
//
// Single-cycle add/and/xor and a pipelined multiply whose start-to-done
// latency is MUL_LAT cycles. Operands and opcode are captured on the edge
// that accepts a request, so the live inputs may change freely afterwards.
//
// Parameters:
//   DW       operand width; the result is 2*DW bits wide
//   MUL_LAT  cycles from the accepting edge to done for a multiply (2..6)
//
// Ports:
//   clk     single clock, all logic on posedge
//   reset   synchronous, active-high reset
//   A, B    unsigned operands (DW bits)
//   op      opcode: 000 nop, 001 add, 010 and, 011 xor, 100 mul, 111 rst
//           (rst is a no-op; 101/110 are reserved and also ignored)
//   start   request, sampled only while idle
//   done    one-cycle pulse; result is valid in the same cycle
//   result  registered, zero-extended result, held until the next done
// ---------------------------------------------------------------------------
module tinyalu #(
  parameter int DW      = 9,
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DW-1:0]   A,
  input  logic [DW-1:0]   B,
  input  logic [2:0]      op,
  input  logic            start,
  output logic            done,
  output logic [2*DW-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SINGLE,
    S_MUL,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_MUL = 3'b100,
    OP_RST = 3'b111
  } op_t;

  localparam int RW = 2 * DW;

  state_t          state_q, state_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            mul_last_q, mul_last_d;
  logic [RW-1:0]   prod_q, prod_d;
  logic            done_q, done_d;
  logic [RW-1:0]   result_q, result_d;

  // NOTE: every signal written here gets a default before the case
  // statement, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    mul_last_d = mul_last_q;
    done_d     = 1'b0;
    result_d   = result_q;
    // First multiplier stage runs every cycle; the operands are frozen for
    // the whole MUL phase, so prod_q is stable by the time it is consumed.
    prod_d     = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d  = A;
          b_d  = B;
          op_d = op;
          // An unknown opcode matches no item and falls to the default,
          // which keeps the ALU idle just like a reserved code.
          case (op)
            OP_ADD, OP_AND, OP_XOR: state_d = S_SINGLE;
            OP_MUL: begin
              state_d    = S_MUL;
              cnt_d      = 3'(MUL_LAT - 2);
              mul_last_d = 1'b0;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      S_SINGLE: begin
        case (op_q)
          OP_ADD:  result_d = {{(DW-1){1'b0}}, ({1'b0, a_q} + {1'b0, b_q})};
          OP_AND:  result_d = {{DW{1'b0}}, (a_q & b_q)};
          OP_XOR:  result_d = {{DW{1'b0}}, (a_q ^ b_q)};
          default: result_d = result_q;
        endcase
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      S_MUL: begin
        // The counter reaches zero one cycle before the final edge; the
        // mul_last flag spends that extra cycle so done lands exactly
        // MUL_LAT edges after acceptance (and the product has settled).
        if (mul_last_q) begin
          result_d   = prod_q;
          done_d     = 1'b1;
          mul_last_d = 1'b0;
          state_d    = S_DONE;
        end else if (cnt_q == 3'd0) begin
          mul_last_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      S_DONE: begin
        // start is deliberately not looked at here; a held start is picked
        // up on the next idle edge.
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      mul_last_q <= 1'b0;
      prod_q     <= '0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      mul_last_q <= mul_last_d;
      prod_q     <= prod_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: doc/tinyalu.md
Name: tinyalu

Overview:
- Synthesizable ALU that consumes the operand/opcode/start stimulus driven by the testbench bus-functional interface.
- Returns a result together with a one-cycle done pulse.
- Single-cycle datapath for add/and/xor; multi-cycle datapath for multiply.
- Sits directly below the bench interface; the bench exercises it through A, B, op, start and observes done and result.

Parameters:
- DW, 9, operand width; result width is 2*DW.
- MUL_LAT, 3, clock cycles from the start-sampling edge to done for mul_op; legal range 2..6.

Ports:
- clk  in  1  single clock; all logic is posedge.
- reset  in  1  synchronous, active-high reset.
- A  in  DW  operand A, unsigned.
- B  in  DW  operand B, unsigned.
- op  in  3  opcode: 000 no_op, 001 add_op, 010 and_op, 011 xor_op, 100 mul_op, 111 rst_op; 101/110 reserved.
- start  in  1  request; sampled only in IDLE.
- done  out  1  one-cycle pulse; result is valid in the same cycle.
- result  out  2*DW  registered result, zero-extended, held until the next done.

Behaviour:
- Reset (sampled at posedge with reset=1):
  - state goes to IDLE; done=0; result=0; operand/opcode registers cleared.
  - Reset overrides start in the same cycle.
  - Reset mid-operation aborts the operation: no done is ever produced for it.
- States: IDLE, SINGLE, MUL, DONE.
- Let E0 be the edge at which state=IDLE and start=1.
- At E0:
  - A, B and op are latched into internal registers; the live inputs are ignored afterwards.
  - add/and/xor: go to SINGLE.
  - mul: go to MUL; the cycle counter is loaded with MUL_LAT-2.
  - no_op, rst_op, 101, 110: stay in IDLE; no done; result unchanged. rst_op here is a no-op; the real reset comes from the reset port.
- SINGLE, at E0+1:
  - result <= the operation on the latched operands; done <= 1; go to DONE.
  - add: zero-extend DW+1 bits (carry kept). and/xor: DW bits, zero-extended.
- MUL:
  - Counter decrements each cycle; the product is pipelined internally (at least 2 register stages).
  - At E0+MUL_LAT: result <= A*B (full 2*DW-bit unsigned); done <= 1; go to DONE.
- DONE (one cycle):
  - At the next edge, done <= 0 and state returns to IDLE.
  - start is not sampled in DONE. A start still high after the DONE cycle is taken as a new request at the following IDLE edge (back-to-back operations allowed).
- start and op changes while in SINGLE/MUL/DONE are ignored.
- done is never high for two consecutive cycles.
- done is high only in the cycle after SINGLE or the final MUL cycle.
- result changes only on the edge that raises done, or on reset.
- Overflow boundaries:
  - add 511+511=1022 (bit 9 set).
  - mul 511*511=261121 (0x3FC01), which fits in 18 bits; no wrap.
- X/undefined op at E0 is treated as reserved: stay in IDLE.

Test Plan:
- Reset for 2 cycles, then release -> done=0, result=0; with start=0 for 10 cycles, done stays 0.
- add: A=9'h1FF, B=9'h1FF, start held until done -> done pulses exactly 1 cycle at E0+1; result=18'd1022; start dropped the next negedge -> IDLE, no second done.
- and/xor: A=9'h155, B=9'h0F3 -> and gives result=18'h051 at E0+1; xor gives result=18'h1A6; result holds through 5 idle cycles.
- mul (MUL_LAT=3): A=511, B=511 -> done only at E0+3, result=18'h3FC01. Toggling A/B/op during MUL does not affect the result. A second mul (12*10) issued with start held high through DONE -> result=120 at the new E0+3.
- no_op, 3'b101, rst_op with start high 1 cycle -> no done within 10 cycles; result keeps its previous value (e.g. 120).
- reset asserted at E0+1 of a mul -> done never pulses; result=0. The next add 3+4 -> result=7, done at E0+1.
